// File: rtl/accel_job_arbiter.sv
// accel_job_arbiter: round-robin job arbiter for a shared area-check
// accelerator, with tagged responses and a hang watchdog.
module accel_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDW         = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   acc_in_valid,
  output logic [31:0]            acc_in_data,
  input  logic                   acc_in_ready,
  input  logic                   acc_out_valid,
  input  logic [31:0]            acc_out_data,
  output logic                   acc_out_ready,
  output logic                   acc_rst_n,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic [1:0]             rsp_status,
  output logic [31:0]            rsp_cycles,
  output logic                   busy,
  output logic [15:0]            jobs_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STREAM  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_ACC_RST = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_OVR = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  localparam logic [31:0]    TMO_MAX = 32'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] RR_INIT = IDW'(NUM_REQ - 1);

  logic [2:0]     state;
  logic [2:0]     state_d;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last_grant;
  logic [31:0]    cyc;
  logic [31:0]    cyc_inc;
  logic [31:0]    tmo_cnt;

  logic           sel_valid;
  logic           sel_last;
  logic [31:0]    sel_data;

  logic           arb_hit;
  logic [IDW-1:0] arb_idx;

  logic           in_hs;
  logic           last_hs;
  logic           res_hs;
  logic           drain_hs;
  logic           drain_last;
  logic           tmo_hit;
  logic           enter_resp;
  logic           counting;

  // Route the granted requester's stream onto shared wires
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant == IDW'(r)) begin
        sel_valid = req_valid[r];
        sel_last  = req_last[r];
        sel_data  = req_data[32*r +: 32];
      end
    end
  end

  // Round-robin pick: first valid above last_grant, then wrap to 0
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!arb_hit && req_valid[r] && (IDW'(r) > last_grant)) begin
        arb_hit = 1'b1;
        arb_idx = IDW'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!arb_hit && req_valid[r] && (IDW'(r) <= last_grant)) begin
        arb_hit = 1'b1;
        arb_idx = IDW'(r);
      end
    end
  end

  // Handshake and event decode for the current state
  always_comb begin
    in_hs      = (state == S_STREAM) && sel_valid && acc_in_ready;
    last_hs    = in_hs && sel_last;
    res_hs     = acc_out_valid && acc_out_ready;
    drain_hs   = (state == S_DRAIN) && sel_valid;
    drain_last = drain_hs && sel_last;
    tmo_hit    = (state == S_WAIT) && !acc_out_valid
                 && (tmo_cnt == TMO_MAX);
    cyc_inc    = (&cyc) ? cyc : cyc + 32'd1;
    counting   = (state == S_STREAM) || (state == S_DRAIN)
                 || (state == S_WAIT) || (state == S_ACC_RST);
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (arb_hit) state_d = S_STREAM;
      end
      S_STREAM: begin
        unique case (1'b1)
          last_hs && acc_out_valid: state_d = S_RESP;
          last_hs:                  state_d = S_WAIT;
          acc_out_valid:            state_d = S_DRAIN;
          default:                  state_d = S_STREAM;
        endcase
      end
      S_WAIT: begin
        unique case (1'b1)
          acc_out_valid: state_d = S_RESP;
          tmo_hit:       state_d = S_ACC_RST;
          default:       state_d = S_WAIT;
        endcase
      end
      S_DRAIN: begin
        if (drain_last) state_d = S_RESP;
      end
      S_ACC_RST: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    enter_resp = (state_d == S_RESP) && (state != S_RESP);
  end

  // Requester accept and accelerator stream outputs
  always_comb begin
    req_ready = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant == IDW'(r)) begin
        req_ready[r] = ((state == S_STREAM) && acc_in_ready)
                       || (state == S_DRAIN);
      end
    end
    acc_in_valid  = (state == S_STREAM) && sel_valid;
    acc_in_data   = sel_data;
    acc_out_ready = (state == S_WAIT)
                    || ((state == S_STREAM) && acc_out_valid);
    acc_rst_n     = rst_n && (state != S_ACC_RST);
    rsp_valid     = (state == S_RESP);
    busy          = (state != S_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Grant, job cycle counter and watchdog counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= RR_INIT;
      cyc        <= '0;
      tmo_cnt    <= '0;
    end else begin
      if ((state == S_IDLE) && arb_hit) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
        cyc        <= '0;
        tmo_cnt    <= '0;
      end else if (counting) begin
        cyc <= cyc_inc;
      end
      if ((state == S_WAIT) && !acc_out_valid) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

  // Response fields, held until the response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      rsp_id     <= '0;
      rsp_cycles <= '0;
    end else begin
      if (res_hs) begin
        rsp_data   <= acc_out_data;
        rsp_status <= ((state == S_STREAM) && !last_hs) ? ST_OVR : ST_OK;
      end else if (state == S_ACC_RST) begin
        rsp_data   <= '0;
        rsp_status <= ST_TMO;
      end
      if (enter_resp) begin
        rsp_cycles <= cyc_inc;
        rsp_id     <= grant;
      end
    end
  end

  // Completed-response counter, wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jobs_done <= '0;
    end else if ((state == S_RESP) && rsp_ready) begin
      jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_accel_job_arbiter.sv
// tb_accel_job_arbiter: directed bench for accel_job_arbiter with a
// scripted accelerator model and per-requester word stores.
module tb_accel_job_arbiter;

  localparam int NR  = 4;
  localparam int IDW = 3;
  localparam int TMO = 64;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [32*NR-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              acc_in_valid;
  logic [31:0]       acc_in_data;
  logic              acc_in_ready;
  logic              acc_out_valid;
  logic [31:0]       acc_out_data;
  logic              acc_out_ready;
  logic              acc_rst_n;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_status;
  logic [31:0]       rsp_cycles;
  logic              busy;
  logic [15:0]       jobs_done;

  accel_job_arbiter #(
    .NUM_REQ    (NR),
    .IDW        (IDW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .acc_in_valid (acc_in_valid),
    .acc_in_data  (acc_in_data),
    .acc_in_ready (acc_in_ready),
    .acc_out_valid(acc_out_valid),
    .acc_out_data (acc_out_data),
    .acc_out_ready(acc_out_ready),
    .acc_rst_n    (acc_rst_n),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_status   (rsp_status),
    .rsp_cycles   (rsp_cycles),
    .busy         (busy),
    .jobs_done    (jobs_done)
  );

  int nchecks = 0;
  int nerrs   = 0;

  logic [32:0] wbuf [NR][64];
  int          wcnt [NR];
  int          wptr [NR];

  int          acc_n [$];
  logic [31:0] acc_res [$];
  logic        acc_v;
  logic [31:0] acc_d;
  int          acc_cnt;
  int          acc_words;
  logic [31:0] acc_x;
  int          r1_ready;

  logic [NR-1:0] hs_req;
  logic          hs_in;
  logic          hs_out;
  logic          hs_rst;
  logic          hs_rstn;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int r, input logic last,
                           input logic [31:0] d);
    wbuf[r][wcnt[r]] = {last, d};
    wcnt[r]++;
  endtask

  task automatic push_case1(input int r);
    push_word(r, 1'b0, 32'h0001_0001);
    push_word(r, 1'b0, 32'h0004_0202);
    push_word(r, 1'b0, 32'h0000_0000);
    push_word(r, 1'b0, 32'h0002_0002);
    push_word(r, 1'b0, 32'h0000_0001);
    push_word(r, 1'b1, 32'h0000_0000);
  endtask

  task automatic acc_push(input int n, input logic [31:0] res);
    acc_n.push_back(n);
    acc_res.push_back(res);
  endtask

  task automatic clear_stores();
    for (int r = 0; r < NR; r++) begin
      wcnt[r] = 0;
      wptr[r] = 0;
    end
    acc_n.delete();
    acc_res.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stores();
    @(negedge clk);
    #2;
    check("rst_acc_rst_n", 32'(acc_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_acc_in_valid", 32'(acc_in_valid), 32'd0);
    check("rst_acc_out_ready", 32'(acc_out_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_rsp_cycles", rsp_cycles, 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);
    clear_stores();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic get_rsp(input string tag, input int hold, input int id,
                         input logic [31:0] data, input int st,
                         input int cyc, input int jobs);
    int n;
    n = 0;
    @(negedge clk);
    #2;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_status"}, 32'(rsp_status), 32'(st));
    check({tag, "_cycles"}, rsp_cycles, 32'(cyc));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #2;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_data, data);
      check({tag, "_hold_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_hold_cycles"}, rsp_cycles, 32'(cyc));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    #2;
    check({tag, "_jobs"}, 32'(jobs_done), 32'(jobs));
    check({tag, "_released"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester feeders and accelerator model
  initial begin
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    acc_in_ready  = 1'b1;
    acc_out_valid = 1'b0;
    acc_out_data  = '0;
    acc_v         = 1'b0;
    acc_d         = '0;
    acc_cnt       = 0;
    acc_words     = 0;
    acc_x         = '0;
    r1_ready      = 0;
    hs_req        = '0;
    hs_in         = 1'b0;
    hs_out        = 1'b0;
    hs_rst        = 1'b0;
    hs_rstn       = 1'b0;
    for (int r = 0; r < NR; r++) begin
      wcnt[r] = 0;
      wptr[r] = 0;
    end
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (hs_req[r] && wptr[r] < wcnt[r]) wptr[r]++;
      end
      if (hs_rst) begin
        acc_v   = 1'b0;
        acc_cnt = 0;
        if (hs_rstn && acc_n.size() > 0) begin
          void'(acc_n.pop_front());
          void'(acc_res.pop_front());
        end
      end else begin
        if (hs_out) begin
          acc_v   = 1'b0;
          acc_cnt = 0;
          if (acc_n.size() > 0) begin
            void'(acc_n.pop_front());
            void'(acc_res.pop_front());
          end
        end
        if (hs_in) begin
          acc_cnt++;
          if (acc_n.size() > 0 && acc_cnt == acc_n[0]) begin
            acc_v = 1'b1;
            acc_d = acc_res[0];
          end
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (wptr[r] < wcnt[r]) begin
          req_valid[r]         = 1'b1;
          req_last[r]          = wbuf[r][wptr[r]][32];
          req_data[32*r +: 32] = wbuf[r][wptr[r]][31:0];
        end else begin
          req_valid[r]         = 1'b0;
          req_last[r]          = 1'b0;
          req_data[32*r +: 32] = '0;
        end
      end
      acc_out_valid = acc_v;
      acc_out_data  = acc_v ? acc_d : 32'd0;
      acc_in_ready  = !acc_v;
      #1;
      hs_req  = req_valid & req_ready;
      hs_in   = acc_in_valid && acc_in_ready;
      hs_out  = acc_out_valid && acc_out_ready;
      hs_rst  = !acc_rst_n;
      hs_rstn = rst_n;
      if (hs_in) begin
        acc_words++;
        acc_x = acc_x ^ acc_in_data;
      end
      if (req_ready[1]) r1_ready++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int w;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    do_reset();

    // single OK job from requester 0
    acc_words = 0;
    acc_x     = '0;
    push_case1(0);
    acc_push(6, 32'd1);
    get_rsp("ok", 0, 0, 32'd1, 0, 7, 1);
    check("ok_acc_words", 32'(acc_words), 32'd6);
    check("ok_acc_xor", acc_x, 32'h0007_0200);

    // round robin with response backpressure on the first grant
    do_reset();
    r1_ready = 0;
    push_case1(0);
    push_case1(2);
    push_case1(3);
    acc_push(6, 32'h100);
    acc_push(6, 32'h102);
    acc_push(6, 32'h103);
    acc_push(6, 32'h200);
    get_rsp("rr0", 10, 0, 32'h100, 0, 7, 1);
    push_case1(0);
    get_rsp("rr2", 0, 2, 32'h102, 0, 7, 2);
    get_rsp("rr3", 0, 3, 32'h103, 0, 7, 3);
    get_rsp("rr0b", 0, 0, 32'h200, 0, 7, 4);
    check("rr_req1_never_ready", 32'(r1_ready), 32'd0);

    // overrun: result arrives after the header, rest is drained
    acc_words = 0;
    acc_x     = '0;
    push_word(1, 1'b0, 32'h0000_0000);
    push_word(1, 1'b0, 32'hAAAA_0001);
    push_word(1, 1'b0, 32'hAAAA_0002);
    push_word(1, 1'b1, 32'hAAAA_0003);
    acc_push(1, 32'd0);
    get_rsp("ovr", 0, 1, 32'd0, 1, 5, 5);
    check("ovr_acc_words", 32'(acc_words), 32'd1);
    check("ovr_all_taken", 32'(wptr[1]), 32'd4);

    // watchdog timeout on a job that never answers
    push_word(2, 1'b1, 32'h0001_0001);
    acc_push(-1, 32'd0);
    n = 0;
    w = 0;
    @(negedge clk);
    #2;
    while (acc_rst_n && n < 300) begin
      if (acc_out_ready) w++;
      @(negedge clk);
      #2;
      n++;
    end
    check("tmo_wait_cycles", 32'(w), 32'd64);
    check("tmo_rst_low", 32'(acc_rst_n), 32'd0);
    @(negedge clk);
    #2;
    check("tmo_rst_one_cycle", 32'(acc_rst_n), 32'd1);
    get_rsp("tmo", 0, 2, 32'd0, 2, 66, 6);
    push_case1(0);
    acc_push(6, 32'd1);
    get_rsp("post_tmo", 0, 0, 32'd1, 0, 7, 7);

    // reset in the middle of requester 3 streaming
    push_case1(3);
    acc_push(6, 32'h33);
    n = 0;
    @(negedge clk);
    #2;
    while (!req_ready[3] && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("mid_r3_granted", 32'(req_ready[3]), 32'd1);
    @(negedge clk);
    do_reset();
    push_case1(3);
    push_case1(0);
    acc_push(6, 32'h30);
    acc_push(6, 32'h33);
    get_rsp("rst_next", 0, 0, 32'h30, 0, 7, 1);
    get_rsp("rst_r3", 0, 3, 32'h33, 0, 7, 2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/accel_job_arbiter.md
# accel_job_arbiter

Shares one Day-12 area-check accelerator between up to `NUM_REQ` job sources, such as host DMA channels or test feeders. It grants one requester at a time by round-robin and streams that requester's job words into the accelerator. It then collects the single result word and returns it on a shared tagged response channel, together with a status code and a cycle count. A watchdog resets the accelerator when a job hangs, so one malformed stream cannot block the other requesters.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDW`, 3: width of the requester ID.
- `TIMEOUT_CYC`, 4096: maximum number of WAIT_RES cycles before the watchdog fires.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous reset, active-low.
- `req_valid` in NUM_REQ: per-requester word valid.
- `req_data` in 32*NUM_REQ: per-requester word; requester r uses bits [32r+31:32r].
- `req_last` in NUM_REQ: marks the final word of a job.
- `req_ready` out NUM_REQ: per-requester accept.
- `acc_in_valid` / `acc_in_data[31:0]` out, `acc_in_ready` in: input stream to the accelerator.
- `acc_out_valid` / `acc_out_data[31:0]` in, `acc_out_ready` out: result from the accelerator.
- `acc_rst_n` out 1: synchronous active-low reset to the accelerator.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out 32: result, or 0 on timeout.
- `rsp_id` out IDW: ID of the granted requester.
- `rsp_status` out 2: 0 = OK, 1 = OVERRUN, 2 = TIMEOUT.
- `rsp_cycles` out 32: job duration in cycles.
- `busy` out 1: high in any state other than IDLE.
- `jobs_done` out 16: count of completed responses; wraps.

## Operation
States are IDLE, STREAM, WAIT_RES, DRAIN, ACC_RST and RESP.

- **IDLE:** if any `req_valid` is high, pick the first set bit searching from `last_grant+1`, modulo NUM_REQ.
  - Register `grant` and set `last_grant` to it.
  - Clear the cycle counter and the timeout counter, then go to STREAM.
  - No word is transferred in IDLE.
- **STREAM:** `acc_in_valid = req_valid[g]`, `acc_in_data = req_data[g]` and `req_ready[g] = acc_in_ready`. All other `req_ready` are 0 and `acc_out_ready` is 0.
  - A handshake with `req_last[g]` high goes to WAIT_RES.
  - If `acc_out_valid` rises before `last`, capture `acc_out_data`, pulse `acc_out_ready` for that cycle, set status to OVERRUN and go to DRAIN.
- **DRAIN:** `req_ready[g] = 1` and words are discarded; `acc_in_valid` is 0. A handshake with `last` goes to RESP.
- **WAIT_RES:** `acc_out_ready = 1`.
  - On `acc_out_valid`, capture the data with status OK and go to RESP.
  - The timeout counter increments every cycle here. When it reaches `TIMEOUT_CYC - 1` without a result, go to ACC_RST.
- **ACC_RST:** `acc_rst_n = 0` for exactly one cycle. Set data to 0 and status to TIMEOUT, then go to RESP.
- **RESP:** `rsp_valid = 1`; all response fields are registered and stable until `rsp_ready`. On the handshake, increment `jobs_done` and go to IDLE.
- **Cycle counter:** 32-bit, saturating at 0xFFFFFFFF. It increments every cycle from STREAM entry up to and including the cycle the response is captured. Its value is latched into `rsp_cycles`.
- **Fairness:** a requester that deasserts `req_valid` mid-job keeps the grant; there is no preemption.

## Timing
- **Reset values:**
  - `state` = IDLE, `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `req_ready`, `acc_in_valid`, `acc_out_ready`, `rsp_valid`, `busy` = 0.
  - `rsp_*`, `jobs_done`, `grant` = 0.
  - `acc_rst_n` = 0 while `rst_n` = 0, otherwise 1.
- **Latency:** one cycle from `req_valid` in IDLE to the first possible STREAM transfer.
- **Data paths:** combinational pass-through from requester to accelerator in STREAM; no buffering and no added latency.
- **Result capture:** the result is captured on the `acc_out_valid & acc_out_ready` cycle. `rsp_valid` rises on the next cycle.
- **Simultaneous events:**
  - A last-word handshake and `acc_out_valid` in the same STREAM cycle counts as OK. Go straight to RESP with the result captured.
  - A new `req_valid` during RESP waits for IDLE.
- **Reset mid-operation:** all state is discarded. Partially streamed jobs are lost, and requesters must restart.

## Test plan
1. **Single OK job:** req0 sends 0x00010001, 0x00040202, 0x00000000, 0x00020002, 0x00000001, then 0x00000000 with `last`. Expect one response: `rsp_id` 0, `rsp_data` 1, `rsp_status` 0, `jobs_done` 1.
2. **Round-robin:** req0, req2 and req3 are valid in the same cycle, each with a complete job. Expect grants in order 0, 2, 3; then req0 re-requests and is granted 0 again, and req1 never receives `req_ready`.
3. **Backpressure:** hold `rsp_ready` low for 10 cycles. Expect all `rsp_*` stable, every `req_ready` 0 and no new grant. After release, `jobs_done` increments exactly once.
4. **Overrun:** req1 sends header 0x00000000, then 3 extra words, the last with `last`. Expect status 1, data 0, all 3 words accepted and dropped, and `rsp_id` 1.
5. **Timeout:** with `TIMEOUT_CYC` = 64, req2 sends header 0x00010001 with `last` set. Expect `acc_rst_n` low for exactly 1 cycle after 64 WAIT_RES cycles, then status 2 and data 0. A following case-1 job returns 1.
6. **Reset mid-STREAM:** assert `rst_n` low for 2 cycles during req3's job. Expect all outputs at their reset values, `acc_rst_n` low, and the next grant to go to req0.
